// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with bounded lock sharing one synchronous RAM between two ports
module mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);
  logic              last_winner, owned, owner, rv0_q, rv1_q;
  logic [7:0]        lock_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              last_winner_n, owned_n, owner_n, rv0_n, rv1_n;
  logic [7:0]        lock_cnt_n;
  logic              keep0, keep1, win1, acc, win_lock;
  // state register; the address is held so the RAM sees a stable address when idle
  always_ff @(posedge clk)
    if (reset) begin
      last_winner <= 1'b1;
      owned       <= 1'b0;
      owner       <= 1'b0;
      lock_cnt    <= 8'd0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      last_winner <= last_winner_n;
      owned       <= owned_n;
      owner       <= owner_n;
      lock_cnt    <= lock_cnt_n;
      rv0_q       <= rv0_n;
      rv1_q       <= rv1_n;
      addr_q      <= mem_addr;
    end
  // winner selection (lock holder, then lone requester, then round-robin) and next state
  always_comb begin
    keep0         = owned && !owner && req0 && (!req1 || lock_cnt < MAX_CNT);
    keep1         = owned && owner && req1 && (!req0 || lock_cnt < MAX_CNT);
    win1          = keep1 ? 1'b1 : keep0 ? 1'b0 : (req0 && req1) ? !last_winner : req1;
    acc           = !reset && (req0 || req1);
    win_lock      = win1 ? lock1 : lock0;
    last_winner_n = acc ? win1 : last_winner;
    owned_n       = acc ? win_lock : owned;
    owner_n       = acc ? win1 : owner;
    lock_cnt_n    = !acc ? lock_cnt : !win_lock ? 8'd0 :
                    (owned && owner == win1) ? lock_cnt + {7'd0, lock_cnt != 8'hFF} : 8'd1;
    rv0_n         = acc && !win1 && !we0;
    rv1_n         = acc && win1 && !we1;
  end
  // grants, RAM drive and read return; a pending read is dropped if reset arrives
  always_comb begin
    gnt0      = acc && !win1;
    gnt1      = acc && win1;
    mem_we    = acc && (win1 ? we1 : we0);
    mem_addr  = !acc ? addr_q : win1 ? addr1 : addr0;
    mem_wdata = !acc ? '0 : win1 ? wdata1 : wdata0;
    rvalid0   = rv0_q && !reset;
    rvalid1   = rv1_q && !reset;
    rdata0    = rvalid0 ? mem_rdata : '0;
    rdata1    = rvalid1 ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed lock sequences and random traffic against a reference model
module tb_mem_arbiter;
  localparam int MAX_LOCK = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  logic [7:0] ram [32];
  logic ram_init = 1'b1;
  always @(posedge clk)
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'h42 + 8'(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end
  int n_vec = 0, n_err = 0;
  int m_owner, m_cnt, m_last, m_laddr, m_w;
  bit m_pend [2];
  logic [7:0] m_prd [2];
  logic [7:0] m_mem [32];
  logic t_chk = 0;
  logic [1:0] t_g, t_rv;
  logic [7:0] t_rd0, t_rd1;
  logic c_g0, c_g1, c_rv0, c_we;
  logic [7:0] c_rd0;
  int exp_lk [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  typedef struct {
    logic rst, r0, w0;
    logic [4:0] a0;
    logic r1, w1, l1;
    logic [4:0] a1;
    logic [7:0] d1;
    logic [1:0] g, rv;
    logic [7:0] rd0, rd1;
  } vec_t;
  vec_t vecs [19];
  function automatic vec_t mk(logic rst, logic r0, logic w0, logic [4:0] a0, logic r1, logic w1,
                              logic l1, logic [4:0] a1, logic [7:0] d1, logic [1:0] g,
                              logic [1:0] rv, logic [7:0] rd0, logic [7:0] rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.l1 = l1;
    v.a1 = a1; v.d1 = d1; v.g = g; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int exp_win();
    bit r [2];
    r[0] = req0; r[1] = req1;
    if (reset) return -1;
    if (m_owner >= 0 && r[m_owner] && (!r[1-m_owner] || m_cnt < MAX_LOCK)) return m_owner;
    if (r[0] && r[1]) return 1 - m_last;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction
  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; m_laddr = 0;
    m_pend[0] = 0; m_pend[1] = 0;
  endtask
  task automatic tick();
    logic [1:0] eg;
    logic [13:0] em;
    logic ev0, ev1, wwe, wlk;
    logic [4:0] wa;
    logic [7:0] wd;
    @(negedge clk);
    m_w = exp_win();
    eg = m_w < 0 ? 2'b00 : m_w == 0 ? 2'b01 : 2'b10;
    em = m_w < 0 ? {1'b0, 5'(m_laddr), 8'h00} : m_w == 0 ? {we0, addr0, wdata0} : {we1, addr1, wdata1};
    ev0 = m_pend[0] && !reset;
    ev1 = m_pend[1] && !reset;
    chk("model_gnt", {gnt1, gnt0}, eg);
    chk("model_mem", {mem_we, mem_addr, mem_wdata}, em);
    chk("model_rd", {rvalid1, rvalid0, rdata1, rdata0},
        {ev1, ev0, ev1 ? m_prd[1] : 8'h00, ev0 ? m_prd[0] : 8'h00});
    if (t_chk) begin
      chk("vec_gnt", {gnt1, gnt0}, t_g);
      chk("vec_rd", {rvalid1, rvalid0, rdata1, rdata0}, {t_rv, t_rd1, t_rd0});
    end
    c_g0 = gnt0; c_g1 = gnt1; c_rv0 = rvalid0; c_rd0 = rdata0; c_we = mem_we;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      m_pend[0] = 0; m_pend[1] = 0;
      if (m_w >= 0) begin
        wwe = m_w ? we1 : we0; wlk = m_w ? lock1 : lock0;
        wa = m_w ? addr1 : addr0; wd = m_w ? wdata1 : wdata0;
        if (wwe) m_mem[wa] = wd;
        else begin m_pend[m_w] = 1; m_prd[m_w] = m_mem[wa]; end
        m_last = m_w; m_laddr = int'(wa);
        if (wlk) begin m_cnt = (m_owner == m_w) ? m_cnt + 1 : 1; m_owner = m_w; end
        else begin m_owner = -1; m_cnt = 0; end
      end
    end
    #1;
  endtask
  task automatic idle();
    req0 = 0; we0 = 0; lock0 = 0; req1 = 0; we1 = 0; lock1 = 0;
  endtask
  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int i;
    for (int k = 0; k < 32; k++) m_mem[k] = 8'h42 + 8'(k);
    model_reset();
    @(posedge clk); #1; ram_init = 0;
    vecs[0]  = mk(1, 0,0,0,  0,0,0,0,0,      2'b00, 2'b00, 8'h00, 8'h00);
    vecs[1]  = mk(0, 1,0,5,  0,0,0,0,0,      2'b01, 2'b00, 8'h00, 8'h00);
    vecs[2]  = mk(0, 0,0,0,  0,0,0,0,0,      2'b00, 2'b01, 8'h47, 8'h00);
    vecs[3]  = mk(1, 0,0,0,  0,0,0,0,0,      2'b00, 2'b00, 8'h00, 8'h00);
    vecs[4]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b01, 2'b00, 8'h00, 8'h00);
    vecs[5]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b10, 2'b01, 8'h43, 8'h00);
    vecs[6]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b01, 2'b10, 8'h00, 8'h44);
    vecs[7]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b10, 2'b01, 8'h43, 8'h00);
    vecs[8]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b01, 2'b10, 8'h00, 8'h44);
    vecs[9]  = mk(0, 1,0,1,  1,0,0,2,0,      2'b10, 2'b01, 8'h43, 8'h00);
    vecs[10] = mk(0, 0,0,0,  0,0,0,0,0,      2'b00, 2'b10, 8'h00, 8'h44);
    vecs[11] = mk(0, 0,0,0,  1,1,0,31,8'hA5, 2'b10, 2'b00, 8'h00, 8'h00);
    vecs[12] = mk(0, 1,0,31, 0,0,0,0,0,      2'b01, 2'b00, 8'h00, 8'h00);
    vecs[13] = mk(0, 0,0,0,  0,0,0,0,0,      2'b00, 2'b01, 8'hA5, 8'h00);
    vecs[14] = mk(0, 0,0,0,  0,0,0,0,0,      2'b00, 2'b00, 8'h00, 8'h00);
    vecs[15] = mk(0, 1,0,5,  0,0,0,0,0,      2'b01, 2'b00, 8'h00, 8'h00);
    vecs[16] = mk(1, 0,0,0,  0,0,0,0,0,      2'b00, 2'b00, 8'h00, 8'h00);
    vecs[17] = mk(0, 1,0,1,  1,0,0,2,0,      2'b01, 2'b00, 8'h00, 8'h00);
    vecs[18] = mk(0, 0,0,0,  0,0,0,0,0,      2'b00, 2'b01, 8'h43, 8'h00);
    t_chk = 1;
    foreach (vecs[k]) begin
      reset = vecs[k].rst; req0 = vecs[k].r0; we0 = vecs[k].w0; lock0 = 0; addr0 = vecs[k].a0;
      wdata0 = 0; req1 = vecs[k].r1; we1 = vecs[k].w1; lock1 = vecs[k].l1; addr1 = vecs[k].a1;
      wdata1 = vecs[k].d1; t_g = vecs[k].g; t_rv = vecs[k].rv; t_rd0 = vecs[k].rd0; t_rd1 = vecs[k].rd1;
      tick();
    end
    t_chk = 0;
    do_reset();
    i = 0;
    req0 = 1; we0 = 0; addr0 = 5'd20; req1 = 1; we1 = 1; lock1 = 1;
    for (int k = 0; k < 20 && i < 12; k++) begin
      addr1 = 5'(i); wdata1 = 8'h10 + 8'(i);
      tick();
      if (k < 14) chk("lock_order", {c_g1, c_g0}, exp_lk[k] == 1 ? 2'b10 : 2'b01);
      else chk("lock_overrun", k, 13);
      if (c_g1) i++;
    end
    chk("lock_done", i, 12);
    idle();
    for (int j = 0; j <= 12; j++) begin
      req0 = j < 12; addr0 = 5'(j);
      tick();
      if (j > 0) chk("readback", {c_rv0, c_rd0}, {1'b1, 8'h10 + 8'(j - 1)});
    end
    do_reset();
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 5'd3; wdata1 = 8'h77;
    tick(); chk("idle_lock_first", {c_g1, c_g0}, 2'b10);
    idle(); tick(); chk("idle_no_we", {c_we, c_g1, c_g0}, 3'b000);
    req0 = 1; addr0 = 5'd4; req1 = 1; we1 = 1; lock1 = 1; addr1 = 5'd4; wdata1 = 8'h78;
    tick(); chk("idle_return1", {c_g1, c_g0}, 2'b10);
    idle(); tick(); chk("idle_no_we2", {c_we, c_g1, c_g0}, 3'b000);
    req0 = 1; addr0 = 5'd4; req1 = 1; we1 = 1; lock1 = 1; addr1 = 5'd5; wdata1 = 8'h79;
    tick(); chk("idle_return2", {c_g1, c_g0}, 2'b10);
    idle(); tick();
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom % 60) == 0;
      req0 = ($urandom % 4) != 0; we0 = $urandom % 2; lock0 = ($urandom % 3) != 0;
      addr0 = 5'($urandom); wdata0 = 8'($urandom);
      req1 = ($urandom % 4) != 0; we1 = $urandom % 2; lock1 = ($urandom % 3) != 0;
      addr1 = 5'($urandom); wdata1 = 8'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
